vx_fpu_rsp_buf: RTL

VX_FPU_RSP_BUF -- requirements
Module: VX_fpu_rsp_buf

---
 rtl/vx_fpu_rsp_buf_pkg.sv | 16 +
 rtl/vx_fpu_fflags_merge.sv | 26 ++
 rtl/vx_fpu_rsp_buf.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vx_fpu_rsp_buf_pkg.sv
// rtl/vx_fpu_rsp_buf_pkg.sv - shared FPU constants and types used by the sqrt response buffer
package vx_fpu_rsp_buf_pkg;

    localparam int FP_FLAGS_BITS = 5;

    localparam int LATENCY_FSQRT = 8;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

endpackage

// File: rtl/vx_fpu_fflags_merge.sv
// rtl/vx_fpu_fflags_merge.sv - lane-masked OR reduction of per-lane FP exception flags
module vx_fpu_fflags_merge
    import vx_fpu_rsp_buf_pkg::*;
#(
    parameter int NUM_LANES = 1
) (
    input  logic [NUM_LANES-1:0]               lane_mask,
    input  logic [NUM_LANES*FP_FLAGS_BITS-1:0] lane_fflags,
    output logic [FP_FLAGS_BITS-1:0]           merged
);

    fflags_t acc;

    // OR together the flags of every active lane; inactive lanes never contribute
    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_mask[i]) begin
                acc = fflags_t'(acc | lane_fflags[i*FP_FLAGS_BITS +: FP_FLAGS_BITS]);
            end
        end
    end

    assign merged = acc;

endmodule

// File: rtl/vx_fpu_rsp_buf.sv
// rtl/vx_fpu_rsp_buf.sv - credit-managed response FIFO behind the sqrt pipe; FPU_RSP_FFLAGS_EN enables fflags storage
module vx_fpu_rsp_buf
    import vx_fpu_rsp_buf_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int TAGW      = 1,
    parameter int DEPTH     = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               issue_fire,
    output logic                               credit_ok,
    input  logic                               enq_valid,
    input  logic [TAGW-1:0]                    enq_tag,
    input  logic [NUM_LANES-1:0]               enq_lane_mask,
    input  logic [NUM_LANES*32-1:0]            enq_result,
    input  logic                               enq_has_fflags,
    input  logic [NUM_LANES*FP_FLAGS_BITS-1:0] enq_fflags,
    output logic                               deq_valid,
    output logic [TAGW-1:0]                    deq_tag,
    output logic [NUM_LANES*32-1:0]            deq_result,
    output logic                               deq_has_fflags,
    output logic [FP_FLAGS_BITS-1:0]           deq_fflags,
    input  logic                               deq_ready,
    output logic                               overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = NUM_LANES * 32;
    localparam int FW = NUM_LANES * FP_FLAGS_BITS;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic          full;
    logic          do_enq;
    logic          do_deq;

    logic [TAGW-1:0] tag_mem [DEPTH];
    logic [RW-1:0]   res_mem [DEPTH];

    logic [NUM_LANES-1:0] head_mask;
    logic [FW-1:0]        head_fflags;

    assign deq_valid = (count != '0);
    assign full      = (count == DEPTH_C);
    assign do_deq    = deq_valid & deq_ready;
    // A full buffer still takes a result when the head leaves in the same cycle
    assign do_enq    = enq_valid & (~full | do_deq);

    // Credits cover both stored entries and ops still travelling through the pipe
    assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < {1'b0, DEPTH_C};

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_enq & ~do_deq) begin
                count <= count + 1'b1;
            end else if (do_deq & ~do_enq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Ops issued but not yet returned; saturates at both ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else if (issue_fire & ~enq_valid) begin
            if (inflight != DEPTH_C) begin
                inflight <= inflight + 1'b1;
            end
        end else if (enq_valid & ~issue_fire) begin
            if (inflight != '0) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

    // Sticky protocol error: result into a full buffer, or a result nobody issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (enq_valid & ((full & ~do_deq) | (inflight == '0))) begin
            overflow <= 1'b1;
        end
    end

    // Payload storage; entries are only read while valid so they need no reset
    always_ff @(posedge clk) begin
        if (do_enq) begin
            tag_mem[wr_ptr] <= enq_tag;
            res_mem[wr_ptr] <= enq_result;
        end
    end

    assign deq_tag    = deq_valid ? tag_mem[rd_ptr] : '0;
    assign deq_result = deq_valid ? res_mem[rd_ptr] : '0;

`ifdef FPU_RSP_FFLAGS_EN
    logic                 hf_mem   [DEPTH];
    logic [NUM_LANES-1:0] mask_mem [DEPTH];
    logic [FW-1:0]        ff_mem   [DEPTH];

    // Exception-flag side storage, written alongside the payload
    always_ff @(posedge clk) begin
        if (do_enq) begin
            hf_mem[wr_ptr]   <= enq_has_fflags;
            mask_mem[wr_ptr] <= enq_lane_mask;
            ff_mem[wr_ptr]   <= enq_fflags;
        end
    end

    assign deq_has_fflags = deq_valid & hf_mem[rd_ptr];
    assign head_mask      = deq_valid ? mask_mem[rd_ptr] : '0;
    assign head_fflags    = deq_valid ? ff_mem[rd_ptr] : '0;
`else
    logic unused_fflags_in;

    assign unused_fflags_in = ^{enq_lane_mask, enq_has_fflags, enq_fflags};
    assign deq_has_fflags   = 1'b0;
    assign head_mask        = '0;
    assign head_fflags      = '0;
`endif

    vx_fpu_fflags_merge #(
        .NUM_LANES(NUM_LANES)
    ) u_fflags_merge (
        .lane_mask  (head_mask),
        .lane_fflags(head_fflags),
        .merged     (deq_fflags)
    );

endmodule
